counter_gate_ctrl: RTL and testbench



---
 rtl/counter_gate_ctrl.sv | 155 +++++++++++++++
 tb/tb_counter_gate_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/counter_gate_ctrl.sv
// counter_gate_ctrl: gating controller for the 8-bit event counter.
// A rising edge on start begins a run that emits len single-cycle enable
// pulses spaced div+1 cycles apart (len==0 runs until stop), followed by a
// one-cycle done pulse. All outputs are registered.
// Optional build macro COUNTER_GATE_SYNC_EN: passes start and stop through
// two-flop synchronizers, which adds two cycles to every input-to-response
// latency. Without it, start and stop must be synchronous to clk.
module counter_gate_ctrl #(
    parameter int DIV_W = 8,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic [LEN_W-1:0] len,
    output logic             enable,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] tick_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [DIV_W-1:0] DIV_ONE = 1;
    localparam logic [LEN_W-1:0] LEN_ONE = 1;

    logic start_in;
    logic stop_in;

`ifdef COUNTER_GATE_SYNC_EN
    // start chain resets high so a start held across reset is not an edge;
    // stop chain resets low so nothing is aborted out of reset.
    logic [1:0] start_sync_reg;
    logic [1:0] stop_sync_reg;

    // Two-flop synchronizers for the asynchronous control inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync_reg <= 2'b11;
            stop_sync_reg  <= 2'b00;
        end else begin
            start_sync_reg <= {start_sync_reg[0], start};
            stop_sync_reg  <= {stop_sync_reg[0], stop};
        end
    end

    assign start_in = start_sync_reg[1];
    assign stop_in  = stop_sync_reg[1];
`else
    assign start_in = start;
    assign stop_in  = stop;
`endif

    logic [1:0]       state_reg,  state_next;
    logic [DIV_W-1:0] pre_reg,    pre_next;
    logic [DIV_W-1:0] div_reg,    div_next;
    logic [LEN_W-1:0] len_reg,    len_next;
    logic [LEN_W-1:0] tick_reg,   tick_next;
    logic             enable_reg, enable_next;
    logic             busy_reg,   busy_next;
    logic             done_reg,   done_next;
    logic             start_q_reg;
    logic             start_rise;
    logic [LEN_W-1:0] tick_inc;

    assign start_rise = start_in & ~start_q_reg;
    assign tick_inc   = tick_reg + LEN_ONE;

    // Next-state logic: enable and done default low so each is a single-cycle
    // pulse unless re-asserted (div_reg==0 re-asserts enable every cycle).
    always_comb begin
        state_next  = state_reg;
        pre_next    = pre_reg;
        div_next    = div_reg;
        len_next    = len_reg;
        tick_next   = tick_reg;
        enable_next = 1'b0;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                // stop is deliberately not looked at here
                if (start_rise) begin
                    div_next   = div;
                    len_next   = len;
                    pre_next   = '0;
                    tick_next  = '0;
                    busy_next  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stop_in) begin
                    done_next  = 1'b1;
                    state_next = DONE;
                end else if (pre_reg == div_reg) begin
                    pre_next    = '0;
                    enable_next = 1'b1;
                    tick_next   = tick_inc;
                    // Last pulse and done share the same cycle
                    if ((len_reg != '0) && (tick_inc == len_reg)) begin
                        done_next  = 1'b1;
                        state_next = DONE;
                    end
                end else begin
                    pre_next = pre_reg + DIV_ONE;
                end
            end
            DONE: begin
                // Any start edge seen here is dropped
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            pre_reg     <= '0;
            div_reg     <= '0;
            len_reg     <= '0;
            tick_reg    <= '0;
            enable_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            start_q_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            pre_reg     <= pre_next;
            div_reg     <= div_next;
            len_reg     <= len_next;
            tick_reg    <= tick_next;
            enable_reg  <= enable_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            start_q_reg <= start_in;
        end
    end

    assign enable   = enable_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign tick_cnt = tick_reg;

endmodule

// File: tb/tb_counter_gate_ctrl.sv
// Directed bench for counter_gate_ctrl (LEN_W=4 so tick_cnt wrap is reachable).
// Expected outputs come from closed-form timing: after edge Ek of a run,
// a pulse is due when k is a multiple of div+1.
module tb_counter_gate_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [7:0] div;
    logic [3:0] len;
    logic       enable;
    logic       busy;
    logic       done;
    logic [3:0] tick_cnt;

    typedef struct packed {
        logic       en;
        logic       bsy;
        logic       dn;
        logic [3:0] tk;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    counter_gate_ctrl #(.DIV_W(8), .LEN_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .div      (div),
        .len      (len),
        .enable   (enable),
        .busy     (busy),
        .done     (done),
        .tick_cnt (tick_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp_now(input exp_t x, input string tag);
        n_cmp++;
        assert (enable === x.en) else begin
            n_fail++;
            $error("FAIL %s enable got %b want %b", tag, enable, x.en);
        end
        n_cmp++;
        assert (busy === x.bsy) else begin
            n_fail++;
            $error("FAIL %s busy got %b want %b", tag, busy, x.bsy);
        end
        n_cmp++;
        assert (done === x.dn) else begin
            n_fail++;
            $error("FAIL %s done got %b want %b", tag, done, x.dn);
        end
        n_cmp++;
        assert (tick_cnt === x.tk) else begin
            n_fail++;
            $error("FAIL %s tick_cnt got %0d want %0d", tag, tick_cnt, x.tk);
        end
        $display("step %-16s en=%b busy=%b done=%b tick=%0d", tag, enable, busy, done, tick_cnt);
    endtask

    // Push the expectation for the coming edge, clock once, pop and compare
    task automatic chk(input logic e, input logic b, input logic d,
                       input logic [3:0] t, input string tag);
        exp_t x;
        exp_q.push_back('{en: e, bsy: b, dn: d, tk: t});
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        cmp_now(x, tag);
    endtask

    // One run: start edge at E0, optional stop at edge stop_at (0 = natural end),
    // optional mid-run start edge and div/len changes that must be ignored.
    task automatic do_run(input int d, input int l, input int stop_at,
                          input bit disturb, input string name);
        int   ticks;
        bit   p;
        bit   fin;
        ticks = 0;
        fin   = 1'b0;
        div   = 8'(d);
        len   = 4'(l);
        start = 1'b1;
        chk(1'b0, 1'b1, 1'b0, 4'd0, {name, " e0"});
        start = 1'b0;
        for (int k = 1; k < 64 && !fin; k++) begin
            if (disturb && k == 2) begin
                start = 1'b1;
                div   = 8'(d + 5);
                len   = 4'(l + 3);
            end
            if (disturb && k == 3) start = 1'b0;
            if (stop_at != 0 && k == stop_at) begin
                stop = 1'b1;
                chk(1'b0, 1'b1, 1'b1, 4'(ticks), $sformatf("%s stop%0d", name, k));
                stop = 1'b0;
                fin  = 1'b1;
            end else begin
                p = ((k % (d + 1)) == 0);
                if (p) ticks++;
                fin = p && (l != 0) && (ticks == l);
                chk(p, 1'b1, fin, 4'(ticks), $sformatf("%s k%0d", name, k));
            end
        end
        if (!fin) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s timeout got no end want end within 63 cycles", name);
        end
        chk(1'b0, 1'b0, 1'b0, 4'(ticks), {name, " idle"});
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        div   = 8'd0;
        len   = 4'd0;
        #2;
        cmp_now('{en: 1'b0, bsy: 1'b0, dn: 1'b0, tk: 4'd0}, "reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk(1'b0, 1'b0, 1'b0, 4'd0, "post_rst");

        // stop alone in IDLE does nothing
        stop = 1'b1;
        chk(1'b0, 1'b0, 1'b0, 4'd0, "stop_idle");
        stop = 1'b0;

        // Basic run, then start edge landing on the DONE edge is lost
        do_run(0, 4, 0, 1'b0, "basic");
        do_run(0, 2, 0, 1'b0, "short");
        // redo last step manually: start rises in the cycle where DONE is live
        div   = 8'd0;
        len   = 4'd1;
        start = 1'b1;
        chk(1'b0, 1'b1, 1'b0, 4'd0, "d1 e0");
        start = 1'b0;
        chk(1'b1, 1'b1, 1'b1, 4'd1, "d1 pulse");
        start = 1'b1;
        chk(1'b0, 1'b0, 1'b0, 4'd1, "d1 start_in_done");
        chk(1'b0, 1'b0, 1'b0, 4'd1, "d1 held_start");
        start = 1'b0;
        chk(1'b0, 1'b0, 1'b0, 4'd1, "d1 quiet");

        do_run(3, 3, 0, 1'b0, "presc");
        do_run(1, 0, 11, 1'b0, "abort");
        chk(1'b0, 1'b0, 1'b0, 4'd5, "abort hold");
        do_run(2, 3, 0, 1'b1, "disturb");
        do_run(0, 0, 21, 1'b0, "wrap");

        // start and stop together in IDLE: run starts, stop acts next edge
        div   = 8'd2;
        len   = 4'd0;
        start = 1'b1;
        stop  = 1'b1;
        chk(1'b0, 1'b1, 1'b0, 4'd0, "ss e0");
        start = 1'b0;
        chk(1'b0, 1'b1, 1'b1, 4'd0, "ss stop");
        stop = 1'b0;
        chk(1'b0, 1'b0, 1'b0, 4'd0, "ss idle");

        // Asynchronous reset mid-run
        div   = 8'd0;
        len   = 4'd0;
        start = 1'b1;
        chk(1'b0, 1'b1, 1'b0, 4'd0, "rr e0");
        chk(1'b1, 1'b1, 1'b0, 4'd1, "rr k1");
        chk(1'b1, 1'b1, 1'b0, 4'd2, "rr k2");
        #2;
        rst_n = 1'b0;
        #1;
        cmp_now('{en: 1'b0, bsy: 1'b0, dn: 1'b0, tk: 4'd0}, "rr async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // start has stayed high through reset release: no run
        chk(1'b0, 1'b0, 1'b0, 4'd0, "rr hold1");
        chk(1'b0, 1'b0, 1'b0, 4'd0, "rr hold2");
        start = 1'b0;
        chk(1'b0, 1'b0, 1'b0, 4'd0, "rr low");
        do_run(1, 2, 0, 1'b0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
